// File: rtl/toccata_audio_pkg.sv
// Shared constants, frame type builder and level-width helper for the Toccata audio FIFO.
package toccata_audio_pkg;

    localparam int unsigned DEF_CHANNELS     = 2;
    localparam int unsigned DEF_SAMPLE_WIDTH = 16;
    localparam int unsigned DEF_DEPTH        = 1024;
    localparam int unsigned DEF_HYST         = 8;
    localparam int unsigned DEF_FRAME_W      = DEF_CHANNELS * DEF_SAMPLE_WIDTH;

    // One frame at the default geometry; channel 0 sits in the LSBs.
    typedef logic [DEF_FRAME_W-1:0] frame_t;

    function automatic int unsigned frame_width(input int unsigned channels,
                                                input int unsigned sample_width);
        return channels * sample_width;
    endfunction

    // Level counters need one extra bit so that "full" (== depth) is representable.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/toccata_sdp_ram.sv
// Simple dual-port frame store: one write port, one registered read port (read-before-write).
module toccata_sdp_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register holds its value between reads; reset clears it.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/toccata_audio_fifo.sv
// Frame-oriented audio FIFO with watermark interrupts (hysteresis) and optional
// sticky underrun/overflow flags enabled by TOCCATA_AUDIO_FIFO_ERR_EN.
module toccata_audio_fifo
    import toccata_audio_pkg::*;
#(
    parameter int unsigned CHANNELS     = DEF_CHANNELS,
    parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned HYST         = DEF_HYST
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             wr_en,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] wr_data,
    output logic                             wr_ready,
    input  logic                             rd_en,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0] rd_data,
    output logic                             rd_valid,
    output logic [$clog2(DEPTH):0]           level,
    input  logic [$clog2(DEPTH):0]           watermark,
    output logic                             irq_below,
    output logic                             irq_above,
    output logic                             underrun,
    output logic                             overflow,
    input  logic                             clear_err
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = lvl_width(DEPTH);
    localparam int unsigned LW1 = LW + 1;
    localparam int unsigned FW  = frame_width(CHANNELS, SAMPLE_WIDTH);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d, wm_q;
    logic          armed_q, armed_d;
    logic          irq_below_q, irq_below_d, irq_above_q, irq_above_d;
    logic          rd_valid_q, rd_valid_d, wr_ready_q, wr_ready_d;
    logic          underrun_q, underrun_d, overflow_q, overflow_d;

    logic          full_c, empty_c, wr_acc_c, rd_acc_c, hit_below_c, hit_above_c;
    logic [LW:0]   below_tgt_c, above_tgt_c;

    // Targets computed one bit wider so an out-of-range target can never match.
    always_comb begin
        full_c      = (level_q == LW'(DEPTH));
        empty_c     = (level_q == '0);
        wr_acc_c    = wr_en && !full_c && !flush;
        rd_acc_c    = rd_en && !empty_c && !flush;
        below_tgt_c = {1'b0, wm_q} - LW1'(HYST);
        above_tgt_c = {1'b0, wm_q} + LW1'(HYST);
        hit_below_c = !below_tgt_c[LW] && (below_tgt_c[LW-1:0] == level_q);
        hit_above_c = (above_tgt_c == {1'b0, level_q});
    end

    always_comb begin
        wptr_d      = wptr_q + AW'(wr_acc_c);
        rptr_d      = rptr_q + AW'(rd_acc_c);
        level_d     = level_q;
        armed_d     = armed_q;
        irq_below_d = 1'b0;
        irq_above_d = 1'b0;
        rd_valid_d  = rd_acc_c;
        underrun_d  = 1'b0;
        overflow_d  = 1'b0;

        case ({wr_acc_c, rd_acc_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (level_q == wm_q) begin
            armed_d = 1'b1;
        end else if (armed_q && hit_below_c) begin
            irq_below_d = 1'b1;
            armed_d     = 1'b0;
        end else if (armed_q && hit_above_c) begin
            irq_above_d = 1'b1;
            armed_d     = 1'b0;
        end

`ifdef TOCCATA_AUDIO_FIFO_ERR_EN
        // Empty read replays the held rd_data with a valid pulse; a new set beats clear_err.
        rd_valid_d = rd_acc_c || (rd_en && empty_c && !flush);
        underrun_d = (underrun_q && !clear_err) || (rd_en && empty_c && !flush);
        overflow_d = (overflow_q && !clear_err) || (wr_en && full_c && !flush);
`endif

        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            armed_d     = 1'b0;
            irq_below_d = 1'b0;
            irq_above_d = 1'b0;
        end

        wr_ready_d = (level_d != LW'(DEPTH));
    end

`ifndef TOCCATA_AUDIO_FIFO_ERR_EN
    logic unused_clear_err_c;
    assign unused_clear_err_c = clear_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            armed_q     <= 1'b0;
            irq_below_q <= 1'b0;
            irq_above_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_ready_q  <= 1'b1;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            armed_q     <= armed_d;
            irq_below_q <= irq_below_d;
            irq_above_q <= irq_above_d;
            rd_valid_q  <= rd_valid_d;
            wr_ready_q  <= wr_ready_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

    // Watermark is sampled so a change takes effect from the following cycle.
    always_ff @(posedge clk) begin
        wm_q <= watermark;
    end

    toccata_sdp_ram #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_i   (rst),
        .we_i    (wr_acc_c),
        .waddr_i (wptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_acc_c),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign level     = level_q;
    assign irq_below = irq_below_q;
    assign irq_above = irq_above_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_toccata_audio_fifo.sv
// Randomized bench for toccata_audio_fifo against a queue-based reference model.
module tb_toccata_audio_fifo;

    localparam int CH    = 2;
    localparam int SW    = 16;
    localparam int DEPTH = 1024;
    localparam int HYST  = 8;
    localparam int FW    = CH * SW;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TOCCATA_AUDIO_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk, rst, flush, wr_en, rd_en, clear_err;
    logic [FW-1:0] wr_data, rd_data;
    logic          wr_ready, rd_valid, irq_below, irq_above, underrun, overflow;
    logic [LW-1:0] level, watermark;

    toccata_audio_fifo #(
        .CHANNELS     (CH),
        .SAMPLE_WIDTH (SW),
        .DEPTH        (DEPTH),
        .HYST         (HYST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .level     (level),
        .watermark (watermark),
        .irq_below (irq_below),
        .irq_above (irq_above),
        .underrun  (underrun),
        .overflow  (overflow),
        .clear_err (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, outputs as the values due after the next edge.
    logic [FW-1:0] mq[$];
    logic [FW-1:0] m_rd_data = '0;
    bit m_rd_valid, m_irq_b, m_irq_a, m_armed, m_under, m_over;
    int m_wm = 0;
    int irq_b_cnt = 0;
    int irq_a_cnt = 0;

    task automatic model_step();
        int lvl;
        bit wacc, racc, fb, fa, su, so;
        lvl = mq.size();
        if (rst) begin
            mq.delete();
            m_rd_data = '0; m_rd_valid = 0; m_irq_b = 0; m_irq_a = 0;
            m_armed = 0; m_under = 0; m_over = 0;
        end else if (flush) begin
            mq.delete();
            m_rd_valid = 0; m_irq_b = 0; m_irq_a = 0; m_armed = 0;
            if (ERR && clear_err) begin m_under = 0; m_over = 0; end
        end else begin
            wacc = wr_en && lvl < DEPTH;
            racc = rd_en && lvl > 0;
            fb = m_armed && m_wm >= HYST && lvl == m_wm - HYST;
            fa = m_armed && lvl == m_wm + HYST;
            m_irq_b = 0; m_irq_a = 0;
            if (lvl == m_wm) m_armed = 1;
            else if (fb) begin m_irq_b = 1; m_armed = 0; end
            else if (fa) begin m_irq_a = 1; m_armed = 0; end
            su = ERR && rd_en && lvl == 0;
            so = ERR && wr_en && lvl == DEPTH;
            if (racc) begin m_rd_data = mq.pop_front(); m_rd_valid = 1; end
            else m_rd_valid = su;
            if (wacc) mq.push_back(wr_data);
            m_under = (m_under && !(ERR && clear_err)) || su;
            m_over  = (m_over && !(ERR && clear_err)) || so;
        end
        m_wm = int'(watermark);
    endtask

    // One clock: advance the model with the driven inputs, then compare every output.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("level",     64'(level),     64'(mq.size()));
        check("wr_ready",  64'(wr_ready),  64'(mq.size() != DEPTH));
        check("rd_valid",  64'(rd_valid),  64'(m_rd_valid));
        check("rd_data",   64'(rd_data),   64'(m_rd_data));
        check("irq_below", 64'(irq_below), 64'(m_irq_b));
        check("irq_above", 64'(irq_above), 64'(m_irq_a));
        check("underrun",  64'(underrun),  64'(m_under));
        check("overflow",  64'(overflow),  64'(m_over));
        irq_b_cnt += int'(irq_below);
        irq_a_cnt += int'(irq_above);
    endtask

    task automatic wr(input logic [FW-1:0] d);
        wr_en = 1'b1; rd_en = 1'b0; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd();
        rd_en = 1'b1; wr_en = 1'b0;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    logic [FW-1:0] f0;

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_err = 1'b0;
        wr_data = '0; watermark = LW'(512);
        idle(3);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ready", 64'(wr_ready), 64'd1);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        idle(2);

        // Single frame round trip.
        wr(32'hBEEF_1234);
        rd();
        check("beef_data", 64'(rd_data), 64'h0000_0000_BEEF_1234);
        check("beef_valid", 64'(rd_valid), 64'd1);
        idle(1);
        check("beef_pulse", 64'(rd_valid), 64'd0);
        check("beef_hold", 64'(rd_data), 64'h0000_0000_BEEF_1234);

        // Fill to capacity, overflow attempt, drain in order.
        for (int i = 0; i < DEPTH; i++) wr(FW'(i));
        check("full_level", 64'(level), 64'(DEPTH));
        check("full_ready", 64'(wr_ready), 64'd0);
        wr(32'hDEAD_0000);
        check("drop_level", 64'(level), 64'(DEPTH));
        check("overflow_flag", 64'(overflow), 64'(ERR));
        clear_err = 1'b1; cyc(); clear_err = 1'b0;
        check("overflow_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd();
            check("fill_order", 64'(rd_data), 64'(i));
        end

        // Move the pointers, then run simultaneous traffic at level 500 across the wrap.
        wr(FW'($urandom));
        wr_en = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < 600; i++) begin wr_data = FW'($urandom); cyc(); end
        wr_en = 1'b0; rd_en = 1'b0;
        rd();
        for (int i = 0; i < 500; i++) wr(FW'($urandom));
        wr_en = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_data = FW'($urandom);
            cyc();
            check("steady_level", 64'(level), 64'd500);
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // Watermark hysteresis at 512 +/- 8.
        do_flush();
        irq_b_cnt = 0; irq_a_cnt = 0;
        for (int i = 0; i < 512; i++) wr(FW'(i));
        for (int i = 0; i < 8; i++) rd();
        idle(2);
        check("below_once", 64'(irq_b_cnt), 64'd1);
        check("above_none", 64'(irq_a_cnt), 64'd0);
        for (int i = 0; i < 7; i++) wr(FW'($urandom));
        idle(2);
        for (int i = 0; i < 7; i++) rd();
        idle(2);
        check("below_disarmed", 64'(irq_b_cnt), 64'd1);
        for (int i = 0; i < 16; i++) wr(FW'($urandom));
        idle(2);
        check("above_rearmed", 64'(irq_a_cnt), 64'd1);
        check("below_still", 64'(irq_b_cnt), 64'd1);

        // Flush mid-stream at level 300.
        do_flush();
        f0 = FW'($urandom);
        wr(f0);
        for (int i = 1; i < 301; i++) wr(FW'($urandom));
        rd();
        check("pre_flush_level", 64'(level), 64'd300);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hFFFF_FFFF;
        cyc();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check("flush_level", 64'(level), 64'd0);
        check("flush_rd_data", 64'(rd_data), 64'(f0));
        check("flush_rd_valid", 64'(rd_valid), 64'd0);
        wr(32'h1111_2222);
        rd();
        check("post_flush_data", 64'(rd_data), 64'h0000_0000_1111_2222);

        // Empty read after last frame, and set-beats-clear.
        wr(32'h0000_55AA);
        rd();
        rd();
        check("underrun_flag", 64'(underrun), 64'(ERR));
        check("underrun_data", 64'(rd_data), 64'h0000_0000_0000_55AA);
        check("underrun_valid", 64'(rd_valid), 64'(ERR));
        clear_err = 1'b1; cyc(); clear_err = 1'b0;
        check("underrun_clr", 64'(underrun), 64'd0);
        clear_err = 1'b1; rd(); clear_err = 1'b0;
        check("set_wins", 64'(underrun), 64'(ERR));
        clear_err = 1'b1; cyc(); clear_err = 1'b0;

        // Reset aborts an in-flight read.
        wr(32'hCAFE_F00D);
        rd_en = 1'b1; rst = 1'b1;
        cyc();
        rd_en = 1'b0; rst = 1'b0;
        check("rst_abort_valid", 64'(rd_valid), 64'd0);
        check("rst_abort_level", 64'(level), 64'd0);

        // Random traffic with shifting bias, small watermarks, occasional flush/clear.
        for (int i = 0; i < 2000; i++) begin
            bit wbias;
            wbias     = ((i / 250) % 2) == 0;
            wr_en     = wbias ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            rd_en     = wbias ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            wr_data   = FW'($urandom);
            flush     = ($urandom_range(0, 299) == 0);
            clear_err = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) watermark = LW'($urandom_range(0, 60));
            cyc();
        end
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clear_err = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
